// File: rtl/hw5prob2_pkg.sv
// Shared types for the hw5prob2 colour FSM and its stimulus driver.
// Colour encoding must match the FSM; drv_state_t is private to the driver.
package hw5prob2_pkg;

    typedef enum logic [2:0] {
        RED   = 3'd0,
        PINK  = 3'd1,
        BLUE  = 3'd2,
        GOLD  = 3'd3,
        GREEN = 3'd4
    } color_t;

    typedef enum logic [2:0] {
        D_RED      = 3'd0,
        D_TO_BLUE  = 3'd1,
        D_BLUE     = 3'd2,
        D_TO_GOLD  = 3'd3,
        D_TO_GREEN = 3'd4,
        D_GREEN    = 3'd5
    } drv_state_t;

    // Only colours with a hold input can be requested as a destination.
    function automatic logic is_park(color_t c);
        return (c == RED) || (c == BLUE) || (c == GREEN);
    endfunction

    function automatic logic is_park_state(drv_state_t s);
        return (s == D_RED) || (s == D_BLUE) || (s == D_GREEN);
    endfunction

    // FSM colour seen while the driver presents the outputs of state s.
    function automatic color_t state_color(drv_state_t s);
        color_t c;
        case (s)
            D_BLUE:     c = BLUE;
            D_TO_GREEN: c = GOLD;
            D_GREEN:    c = GREEN;
            default:    c = RED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hw5prob2_driver_if.sv
// Request handshake plus FSM drive/status bundle for hw5prob2_driver.
// master = requester side, slave = driver side.
interface hw5prob2_driver_if;
    import hw5prob2_pkg::*;

    logic   req_valid;
    color_t req_target;
    logic   req_ready;
    logic   hue;
    logic   value;
    logic   fsm_reset_n;
    color_t cur_state;
    logic   done;
    logic   err;
    logic   busy;

    modport master (
        output req_valid, req_target,
        input  req_ready, hue, value, fsm_reset_n, cur_state, done, err, busy
    );

    modport slave (
        input  req_valid, req_target,
        output req_ready, hue, value, fsm_reset_n, cur_state, done, err, busy
    );
endinterface

// File: rtl/hw5prob2_driver.sv
// Steers the hw5prob2 colour FSM to a requested park colour and holds it there.
// Outputs are registered from the next driver state so fsm_reset_n never glitches.
module hw5prob2_driver
    import hw5prob2_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    hw5prob2_driver_if.slave drv
);

    drv_state_t state, state_nxt;
    logic       pend_vld, pend_vld_nxt;
    color_t     pend_tgt, pend_tgt_nxt;
    logic       done_q, done_nxt;
    logic       err_q, err_nxt;
    logic       rst_n_q, rst_n_nxt;
    logic [1:0] hv_q, hv_nxt;
    color_t     cur_q, cur_nxt;
    logic       ready;
    logic       accept;
    logic       steer;
    color_t     goal;

    assign ready  = is_park_state(state) && !pend_vld;
    assign accept = drv.req_valid && ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= D_RED;
            pend_vld <= 1'b0;
            pend_tgt <= RED;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rst_n_q  <= 1'b0;
            hv_q     <= 2'b00;
            cur_q    <= RED;
        end else begin
            state    <= state_nxt;
            pend_vld <= pend_vld_nxt;
            pend_tgt <= pend_tgt_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
            rst_n_q  <= rst_n_nxt;
            hv_q     <= hv_nxt;
            cur_q    <= cur_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        pend_vld_nxt = pend_vld;
        pend_tgt_nxt = pend_tgt;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        steer        = pend_vld;
        goal         = pend_tgt;

        if (accept) begin
            if (is_park(drv.req_target)) begin
                steer = 1'b1;
                goal  = drv.req_target;
            end else begin
                err_nxt = 1'b1;
            end
        end

        case (state)
            D_TO_BLUE:  state_nxt = D_BLUE;
            D_TO_GOLD:  state_nxt = D_TO_GREEN;
            D_TO_GREEN: state_nxt = D_GREEN;
            D_RED: begin
                if (steer) begin
                    case (goal)
                        BLUE:    state_nxt = D_TO_BLUE;
                        GREEN:   state_nxt = D_TO_GOLD;
                        default: state_nxt = D_RED;
                    endcase
                end
            end
            default: begin
                // Leaving Blue or Green always passes through a forced Red.
                if (steer && goal != state_color(state)) state_nxt = D_RED;
            end
        endcase

        if (steer) begin
            if (is_park_state(state_nxt) && state_color(state_nxt) == goal) begin
                done_nxt     = 1'b1;
                pend_vld_nxt = 1'b0;
            end else begin
                pend_vld_nxt = 1'b1;
                pend_tgt_nxt = goal;
            end
        end
    end

    // Output logic, decoded from the state being entered
    always_comb begin
        rst_n_nxt = 1'b1;
        hv_nxt    = 2'b00;
        cur_nxt   = state_color(state_nxt);
        case (state_nxt)
            D_RED:     rst_n_nxt = 1'b0;
            D_TO_BLUE: hv_nxt    = 2'b10;
            D_GREEN:   hv_nxt    = 2'b11;
            default:   hv_nxt    = 2'b01;
        endcase
    end

    assign drv.req_ready   = ready;
    assign drv.busy        = !ready;
    assign drv.fsm_reset_n = rst_n_q;
    assign drv.hue         = hv_q[1];
    assign drv.value       = hv_q[0];
    assign drv.cur_state   = cur_q;
    assign drv.done        = done_q;
    assign drv.err         = err_q;

endmodule

// File: tb/tb_hw5prob2_driver.sv
// Directed bench for hw5prob2_driver with a behavioural model of the colour FSM it drives.
module tb_hw5prob2_driver;
    import hw5prob2_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    hw5prob2_driver_if bus ();

    hw5prob2_driver dut (
        .clock (clock),
        .reset (reset),
        .drv   (bus.slave)
    );

    always #5 clock = ~clock;

    // Colour FSM model: only the edges the driver should use; anything else lands on 7.
    color_t fsm_st;
    always @(posedge clock or negedge bus.fsm_reset_n) begin
        if (!bus.fsm_reset_n) fsm_st <= RED;
        else begin
            case ({fsm_st, bus.hue, bus.value})
                {RED,   2'b10}: fsm_st <= BLUE;
                {RED,   2'b01}: fsm_st <= GOLD;
                {GOLD,  2'b01}: fsm_st <= GREEN;
                {BLUE,  2'b01}: fsm_st <= BLUE;
                {GREEN, 2'b11}: fsm_st <= GREEN;
                default:        fsm_st <= color_t'(3'd7);
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Checks drive outputs, shadow state and the modelled FSM state together.
    task automatic chk_drive(input string tag, input logic rn, input logic [1:0] hv, input color_t c);
        chk({tag, ".rst_n"}, {3'b0, bus.fsm_reset_n}, {3'b0, rn});
        chk({tag, ".hv"}, {2'b0, bus.hue, bus.value}, {2'b0, hv});
        chk({tag, ".cur"}, {1'b0, bus.cur_state}, {1'b0, c});
        chk({tag, ".fsm"}, {1'b0, fsm_st}, {1'b0, c});
    endtask

    task automatic chk_flags(input string tag, input logic d, input logic e, input logic rdy);
        chk({tag, ".done"}, {3'b0, bus.done}, {3'b0, d});
        chk({tag, ".err"}, {3'b0, bus.err}, {3'b0, e});
        chk({tag, ".ready"}, {3'b0, bus.req_ready}, {3'b0, rdy});
        chk({tag, ".busy"}, {3'b0, bus.busy}, {3'b0, !rdy});
    endtask

    task automatic request(input color_t c);
        bus.req_valid  = 1'b1;
        bus.req_target = c;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_target = RED;
        tick();
        tick();
        reset = 1'b0;
        chk_drive("rst", 1'b0, 2'b00, RED);
        chk_flags("rst", 1'b0, 1'b0, 1'b1);

        // Red -> Blue: two edges
        request(BLUE);
        chk_drive("r2b.e1", 1'b1, 2'b10, RED);
        chk_flags("r2b.e1", 1'b0, 1'b0, 1'b0);
        tick();
        chk_drive("r2b.e2", 1'b1, 2'b01, BLUE);
        chk_flags("r2b.e2", 1'b1, 1'b0, 1'b1);
        tick();
        chk_drive("blue.hold", 1'b1, 2'b01, BLUE);
        chk_flags("blue.hold", 1'b0, 1'b0, 1'b1);

        // Blue -> Green via Red: four edges, ready held low while pending
        bus.req_target = GREEN;
        bus.req_valid  = 1'b1;
        tick();
        chk_drive("b2g.e1", 1'b0, 2'b00, RED);
        chk_flags("b2g.e1", 1'b0, 1'b0, 1'b0);
        bus.req_target = BLUE;
        tick();
        bus.req_valid = 1'b0;
        chk_drive("b2g.e2", 1'b1, 2'b01, RED);
        chk_flags("b2g.e2", 1'b0, 1'b0, 1'b0);
        tick();
        chk_drive("b2g.e3", 1'b1, 2'b01, GOLD);
        chk_flags("b2g.e3", 1'b0, 1'b0, 1'b0);
        tick();
        chk_drive("b2g.e4", 1'b1, 2'b11, GREEN);
        chk_flags("b2g.e4", 1'b1, 1'b0, 1'b1);
        tick();
        chk_drive("green.hold", 1'b1, 2'b11, GREEN);
        chk_flags("green.hold", 1'b0, 1'b0, 1'b1);

        // Illegal targets while parked Green
        request(PINK);
        chk_drive("pink", 1'b1, 2'b11, GREEN);
        chk_flags("pink", 1'b0, 1'b1, 1'b1);
        tick();
        chk_flags("pink.after", 1'b0, 1'b0, 1'b1);
        request(color_t'(3'd5));
        chk_drive("enc5", 1'b1, 2'b11, GREEN);
        chk_flags("enc5", 1'b0, 1'b1, 1'b1);
        tick();

        // Green -> Red: one edge, then Red holds
        request(RED);
        chk_drive("g2r", 1'b0, 2'b00, RED);
        chk_flags("g2r", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        chk_drive("red.hold", 1'b0, 2'b00, RED);
        chk_flags("red.hold", 1'b0, 1'b0, 1'b1);

        // Same colour Blue: done after one edge, no motion
        request(BLUE);
        tick();
        request(BLUE);
        chk_drive("b2b", 1'b1, 2'b01, BLUE);
        chk_flags("b2b", 1'b1, 1'b0, 1'b1);

        // Blue -> Red, then Red -> Green aborted by reset while FSM is in Gold
        request(RED);
        chk_flags("b2r", 1'b1, 1'b0, 1'b1);
        request(GREEN);
        tick();
        chk_drive("abort.pre", 1'b1, 2'b01, GOLD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_drive("abort", 1'b0, 2'b00, RED);
        chk_flags("abort", 1'b0, 1'b0, 1'b1);
        tick();
        chk_drive("abort.after", 1'b0, 2'b00, RED);
        chk_flags("abort.after", 1'b0, 1'b0, 1'b1);

        // Reset together with a request: request dropped
        reset          = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_target = BLUE;
        tick();
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        tick();
        chk_drive("rst_req", 1'b0, 2'b00, RED);
        chk_flags("rst_req", 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
